// File: rtl/camera_pkg.sv
// Shared types and geometry for the camera capture front end.
// Address packing matches the VGA read side: {x[7:0], y[6:0]}.
package camera_pkg;

  typedef enum logic [1:0] {
    SYNC,
    VBLANK,
    ACTIVE
  } state_t;

  localparam int unsigned SRC_WIDTH_DFLT  = 640;
  localparam int unsigned SRC_HEIGHT_DFLT = 480;
  localparam int unsigned DST_WIDTH       = 160;
  localparam int unsigned DST_HEIGHT      = 120;

  localparam int unsigned X_W    = 8;
  localparam int unsigned Y_W    = 7;
  localparam int unsigned ADDR_W = X_W + Y_W;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned ROW_W  = 9;

endpackage

// File: rtl/pixel_pack.sv
// Pairs camera bytes into 16-bit RGB565 pixels; first byte of a pair lands in [15:8].
// o_valid is combinational and marks the cycle in which the second byte is on i_data.
module pixel_pack (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        i_href,
  input  logic        i_href_rise,
  input  logic [7:0]  i_data,
  output logic        o_valid,
  output logic [15:0] o_pixel
);

  logic       r_phase;
  logic [7:0] r_hi;

  // A line start forces phase 0 so a stray odd byte from the previous line cannot misalign pairs.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_phase <= 1'b0;
      r_hi    <= 8'd0;
    end else if (i_href) begin
      if (i_href_rise || !r_phase) begin
        r_hi    <= i_data;
        r_phase <= 1'b1;
      end else begin
        r_phase <= 1'b0;
      end
    end
  end

  assign o_valid = i_href & r_phase & ~i_href_rise;
  assign o_pixel = {r_hi, i_data};

endmodule

// File: rtl/camera_capture.sv
// Camera capture front end: frame sync FSM, source counters, 4x4 decimation and
// registered RAM write port (wren/pixel/wraddr) plus an end-of-frame pulse.
module camera_capture
  import camera_pkg::*;
#(
  parameter int unsigned SRC_WIDTH  = SRC_WIDTH_DFLT,
  parameter int unsigned SRC_HEIGHT = SRC_HEIGHT_DFLT,
  parameter int unsigned DECIM_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              href,
  input  logic              vref,
  input  logic [7:0]        digital,
  output logic [15:0]       pixel,
  output logic [ADDR_W-1:0] wraddr,
  output logic              wren,
  output logic              frame_done
);

  localparam logic [COL_W-1:0] ColMax  = COL_W'(SRC_WIDTH);
  localparam logic [ROW_W-1:0] RowMax  = ROW_W'(SRC_HEIGHT);
  localparam logic [COL_W-1:0] ColMask = COL_W'((1 << DECIM_LOG2) - 1);
  localparam logic [ROW_W-1:0] RowMask = ROW_W'((1 << DECIM_LOG2) - 1);

  state_t            r_state, w_state_next;
  logic              r_href, r_vref;
  logic [COL_W-1:0]  r_scol;
  logic [ROW_W-1:0]  r_srow;
  logic              r_wren, r_frame_done;
  logic [15:0]       r_pixel;
  logic [ADDR_W-1:0] r_wraddr;

  logic              w_href_rise, w_href_fall, w_vref_rise, w_vref_fall;
  logic              w_active, w_pix_valid, w_keep;
  logic [15:0]       w_pix;

  assign w_href_rise = href & ~r_href;
  assign w_href_fall = ~href & r_href;
  assign w_vref_rise = vref & ~r_vref;
  assign w_vref_fall = ~vref & r_vref;
  assign w_active    = (r_state == ACTIVE);

  pixel_pack u_pixel_pack (
    .clk         (clk),
    .reset_b     (reset_b),
    .i_href      (href),
    .i_href_rise (w_href_rise),
    .i_data      (digital),
    .o_valid     (w_pix_valid),
    .o_pixel     (w_pix)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      SYNC:    if (vref)        w_state_next = VBLANK;
      VBLANK:  if (w_vref_fall) w_state_next = ACTIVE;
      ACTIVE:  if (w_vref_rise) w_state_next = VBLANK;
      default:                  w_state_next = SYNC;
    endcase
  end

  // A vref rise in the same cycle as a completed pixel aborts that pixel.
  assign w_keep = w_active & ~w_vref_rise & w_pix_valid &
                  ((r_scol & ColMask) == '0) & ((r_srow & RowMask) == '0) &
                  (r_scol < ColMax) & (r_srow < RowMax);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= SYNC;
      r_href  <= 1'b0;
      r_vref  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_href  <= href;
      r_vref  <= vref;
    end
  end

  // Counters saturate at the frame limits so oversized lines/frames never wrap into range.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_scol <= '0;
      r_srow <= '0;
    end else if (!w_active || w_vref_rise) begin
      r_scol <= '0;
      r_srow <= '0;
    end else begin
      if (w_href_rise) begin
        r_scol <= '0;
      end else if (w_pix_valid && r_scol != ColMax) begin
        r_scol <= r_scol + COL_W'(1);
      end
      if (w_href_fall && r_srow != RowMax) begin
        r_srow <= r_srow + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_wren       <= 1'b0;
      r_frame_done <= 1'b0;
      r_pixel      <= 16'd0;
      r_wraddr     <= '0;
    end else begin
      r_wren       <= w_keep;
      r_frame_done <= w_active & w_vref_rise & (r_srow >= RowMax);
      if (w_keep) begin
        r_pixel  <= w_pix;
        r_wraddr <= {r_scol[DECIM_LOG2 +: X_W], r_srow[DECIM_LOG2 +: Y_W]};
      end
    end
  end

  assign pixel      = r_pixel;
  assign wraddr     = r_wraddr;
  assign wren       = r_wren;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_camera_capture.sv
// Randomized frame-level bench for camera_capture on a reduced 40x24 source;
// expected writes come from a per-line model of the keep/decimation rules.
module tb_camera_capture;

  localparam int W = 40;
  localparam int H = 24;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        href = 1'b0;
  logic        vref = 1'b0;
  logic [7:0]  digital = 8'd0;
  logic [15:0] pixel;
  logic [14:0] wraddr;
  logic        wren;
  logic        frame_done;

  always #5 clk = ~clk;

  camera_capture #(
    .SRC_WIDTH  (W),
    .SRC_HEIGHT (H),
    .DECIM_LOG2 (2)
  ) dut (
    .clk        (clk),
    .reset_b    (reset_b),
    .href       (href),
    .vref       (vref),
    .digital    (digital),
    .pixel      (pixel),
    .wraddr     (wraddr),
    .wren       (wren),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] pix;
  } wr_t;

  wr_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_wr = 0;
  int   n_fd = 0;
  int   n_push = 0;
  logic prev_wren = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_b) begin
      if (frame_done) begin
        n_fd++;
        check("frame_done_with_wren", 32'(wren), 32'd0);
      end
      if (wren) begin
        n_wr++;
        check("wren_back_to_back", 32'(prev_wren), 32'd0);
        if (exp_q.size() == 0) begin
          check("wren_unexpected", 32'(wren), 32'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wraddr", 32'(wraddr), 32'(e.addr));
          check("pixel", 32'(pixel), 32'(e.pix));
        end
      end
    end
    prev_wren = wren;
  end

  // Writes a source line is expected to produce, given only bytes [0, limit) arrive.
  task automatic push_line(input int row, input logic [7:0] b[], input int limit);
    wr_t e;
    if (row >= H || (row % D) != 0) return;
    for (int p = 0; p < W; p += D) begin
      if (2 * p + 1 < limit) begin
        e.addr = {8'(p / D), 7'(row / D)};
        e.pix  = {b[2 * p], b[2 * p + 1]};
        exp_q.push_back(e);
        n_push++;
      end
    end
  endtask

  task automatic drive_byte(input logic [7:0] v);
    @(negedge clk);
    href    = 1'b1;
    digital = v;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      href = 1'b0;
    end
  endtask

  task automatic run_frame(input int nlines, input int len, input int abort_line,
                           input int abort_byte, input int reset_line, input int reset_byte);
    logic [7:0] b[];
    bit live;
    int fd0, wr0, push0;
    live  = 1'b1;
    fd0   = n_fd;
    wr0   = n_wr;
    push0 = n_push;
    repeat (6) begin
      @(negedge clk);
      href = 1'b0;
      vref = 1'b1;
    end
    @(negedge clk);
    vref = 1'b0;
    idle(4);
    for (int l = 0; l < nlines; l++) begin
      b = new[len];
      foreach (b[i]) b[i] = 8'($urandom);
      if (l == abort_line) begin
        if (live) push_line(l, b, abort_byte);
        for (int i = 0; i <= abort_byte; i++) begin
          drive_byte(b[i]);
          if (i == abort_byte) vref = 1'b1;
        end
        live = 1'b0;
        idle(4);
        break;
      end else if (l == reset_line) begin
        if (live) push_line(l, b, reset_byte - 1);
        for (int i = 0; i < reset_byte; i++) drive_byte(b[i]);
        @(negedge clk);
        reset_b = 1'b0;
        href    = 1'b0;
        #1;
        check("rst_async_wren", 32'(wren), 32'd0);
        check("rst_async_pixel", 32'(pixel), 32'd0);
        check("rst_async_wraddr", 32'(wraddr), 32'd0);
        check("rst_async_frame_done", 32'(frame_done), 32'd0);
        repeat (3) @(negedge clk);
        reset_b = 1'b1;
        live    = 1'b0;
      end else begin
        if (live) push_line(l, b, len);
        for (int i = 0; i < len; i++) drive_byte(b[i]);
      end
      idle(4);
    end
    repeat (8) begin
      @(negedge clk);
      href = 1'b0;
      vref = 1'b1;
    end
    check("frame_done_count", 32'(n_fd - fd0), (live && nlines >= H) ? 32'd1 : 32'd0);
    check("write_count", 32'(n_wr - wr0), 32'(n_push - push0));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_pixel", 32'(pixel), 32'd0);
    check("reset_wraddr", 32'(wraddr), 32'd0);
    check("reset_wren", 32'(wren), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    reset_b = 1'b1;

    // Lines with vref held low after reset must not be captured.
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 2 * W; i++) drive_byte(8'($urandom));
      idle(4);
    end
    check("sync_no_wren", 32'(n_wr), 32'd0);
    check("sync_pixel", 32'(pixel), 32'd0);
    check("sync_wraddr", 32'(wraddr), 32'd0);
    check("sync_frame_done", 32'(n_fd), 32'd0);

    run_frame(H, 2 * W, -1, -1, -1, -1);
    run_frame(H, 2 * W + 1, -1, -1, -1, -1);
    run_frame(H, 2 * W + 20, -1, -1, -1, -1);
    run_frame(H, 2 * W, 12, 40, -1, -1);
    run_frame(H, 2 * W, -1, -1, -1, -1);
    run_frame(H + 6, 2 * W, -1, -1, -1, -1);
    run_frame(H, 2 * W, -1, -1, 8, 21);
    run_frame(H, 2 * W, -1, -1, -1, -1);
    for (int f = 0; f < 4; f++) begin
      run_frame(int'($urandom_range(H - 2, H + 4)), int'($urandom_range(2 * W - 10, 2 * W + 16)),
                -1, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
